alu_pipe: RTL

Parametrised, two-stage pipelined ALU with valid/ready handshaking and a full status-flag set, replacing the fixed 8-bit ALU in the datapath between the register-file read stage and the writeback stage. Operands and opcode are captured on an accepted input beat. The result and flags are presented two cycles later. Full backpressure from the consumer stalls the pipeline without loss. A synchronous flush discards in-flight operations.

---
 rtl/alu_pipe.sv | 176 +++++++++++++++++
 1 files changed

// File: rtl/alu_pipe.sv
`default_nettype none
// ============================================================================
//  Module      : alu_pipe
//  Description : Two-stage pipelined ALU with valid/ready handshaking and a
//                full status-flag set (zero, carry/borrow, overflow, negative,
//                illegal-opcode). Stage 1 captures operands, stage 2 holds the
//                computed result. Acts as a two-entry buffer under backpressure.
//                Optional feature macro: ALU_SHIFT_EN builds the SLL/SRL
//                shifter; without it opcodes 110/111 report alu_illegal.
//  Revision    : 1.0 - initial release
// ============================================================================
module alu_pipe #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] data_a,
    input  logic [WIDTH-1:0] data_b,
    input  logic [2:0]       alu_ctrl,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] alu_out,
    output logic             alu_zero,
    output logic             alu_carry,
    output logic             alu_ovf,
    output logic             alu_neg,
    output logic             alu_illegal
);

    localparam logic [2:0] c_OP_ADD = 3'b000;
    localparam logic [2:0] c_OP_SUB = 3'b001;
    localparam logic [2:0] c_OP_AND = 3'b010;
    localparam logic [2:0] c_OP_OR  = 3'b011;
    localparam logic [2:0] c_OP_XOR = 3'b100;
    localparam logic [2:0] c_OP_SLT = 3'b101;
`ifdef ALU_SHIFT_EN
    localparam int         SHW      = $clog2(WIDTH);
    localparam logic [2:0] c_OP_SLL = 3'b110;
    localparam logic [2:0] c_OP_SRL = 3'b111;
`endif

    // Stage 1 operand registers (not reset: meaningless while r_s1_valid is low)
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [2:0]       r_op;
    logic             r_s1_valid;

    // Stage 2 result registers
    logic [WIDTH-1:0] r_out;
    logic             r_zero;
    logic             r_carry;
    logic             r_ovf;
    logic             r_neg;
    logic             r_illegal;
    logic             r_s2_valid;

    // Handshake and datapath wires
    logic             w_s2_load;
    logic             w_accept;
    logic [WIDTH:0]   w_sum;
    logic [WIDTH:0]   w_diff;
    logic             w_slt;
    logic [WIDTH-1:0] w_res;
    logic             w_carry;
    logic             w_ovf;
    logic             w_illegal;

    // S1 drains into S2 whenever S2 is empty or its beat leaves this cycle;
    // a flush drops any beat offered in the same cycle.
    assign w_s2_load = r_s1_valid & (~r_s2_valid | out_ready);
    assign in_ready  = ~r_s1_valid | w_s2_load;
    assign w_accept  = in_valid & in_ready & ~flush;

    // One extra bit on add/subtract exposes carry-out and unsigned borrow.
    assign w_sum  = {1'b0, r_a} + {1'b0, r_b};
    assign w_diff = {1'b0, r_a} - {1'b0, r_b};
    assign w_slt  = $signed(r_a) < $signed(r_b);

    // Pipeline occupancy: the only control state in the block
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1_valid <= 1'b0;
            r_s2_valid <= 1'b0;
        end else if (flush) begin
            r_s1_valid <= 1'b0;
            r_s2_valid <= 1'b0;
        end else begin
            if (w_accept) begin
                r_s1_valid <= 1'b1;
            end else if (w_s2_load) begin
                r_s1_valid <= 1'b0;
            end
            if (w_s2_load) begin
                r_s2_valid <= 1'b1;
            end else if (out_ready) begin
                r_s2_valid <= 1'b0;
            end
        end
    end

    // Capture operands and opcode on an accepted input beat
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_a  <= data_a;
            r_b  <= data_b;
            r_op <= alu_ctrl;
        end
    end

    // Stage 2 combinational result and flag computation
    always_comb begin
        w_res     = '0;
        w_carry   = 1'b0;
        w_ovf     = 1'b0;
        w_illegal = 1'b0;
        case (r_op)
            c_OP_ADD: begin
                w_res   = w_sum[WIDTH-1:0];
                w_carry = w_sum[WIDTH];
                w_ovf   = (r_a[WIDTH-1] == r_b[WIDTH-1]) &&
                          (w_sum[WIDTH-1] != r_a[WIDTH-1]);
            end
            c_OP_SUB: begin
                w_res   = w_diff[WIDTH-1:0];
                w_carry = w_diff[WIDTH];
                w_ovf   = (r_a[WIDTH-1] != r_b[WIDTH-1]) &&
                          (w_diff[WIDTH-1] != r_a[WIDTH-1]);
            end
            c_OP_AND: w_res = r_a & r_b;
            c_OP_OR:  w_res = r_a | r_b;
            c_OP_XOR: w_res = r_a ^ r_b;
            c_OP_SLT: begin
                w_res   = {{(WIDTH-1){1'b0}}, w_slt};
                w_carry = w_diff[WIDTH];
            end
`ifdef ALU_SHIFT_EN
            c_OP_SLL: w_res = r_a << r_b[SHW-1:0];
            c_OP_SRL: w_res = r_a >> r_b[SHW-1:0];
`endif
            // Shift opcodes without a shifter: zero result flagged illegal
            default:  w_illegal = 1'b1;
        endcase
    end

    // Result and flags are registered together so they always describe one beat
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out     <= '0;
            r_zero    <= 1'b0;
            r_carry   <= 1'b0;
            r_ovf     <= 1'b0;
            r_neg     <= 1'b0;
            r_illegal <= 1'b0;
        end else if (w_s2_load) begin
            r_out     <= w_res;
            r_zero    <= (w_res == '0);
            r_carry   <= w_carry;
            r_ovf     <= w_ovf;
            r_neg     <= w_res[WIDTH-1];
            r_illegal <= w_illegal;
        end
    end

    assign out_valid   = r_s2_valid;
    assign alu_out     = r_out;
    assign alu_zero    = r_zero;
    assign alu_carry   = r_carry;
    assign alu_ovf     = r_ovf;
    assign alu_neg     = r_neg;
    assign alu_illegal = r_illegal;

endmodule
`default_nettype wire
